load_store_unit: RTL
====================

# load_store_unit

Initiator side of the data-memory port in the single-cycle RISC-V datapath. Accepts one load or store request at a time from the core, checks alignment and range, and drives the word-addressed data memory's read/write port. Handles RV32I sub-word accesses: sign or zero extension for loads, and a read-modify-write sequence for stores.

## Interface
Parameters:
- MEM_BYTES, 256: byte size of the attached memory (64 words); the address limit for range checks.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2)
- addr  in  32  byte address
- wdata  in  32  store data; low byte or halfword is used for SB/SH
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; misaligned, out-of-range or illegal funct3
- rdata  out  32  extended load result; valid from done and held until the next load completes
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  32  word-aligned address: {addr_q[31:2], 2'b00}
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data; reads 0 when mem_read is low

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- In IDLE, with req=1: latch we, funct3, addr and wdata into registers, then classify the request.
  - Error conditions: illegal funct3 (loads 3/6/7; stores 3 and above), halfword with addr[0]=1, word with addr[1:0]!=0, or addr >= MEM_BYTES. An error goes to RESP with err=1 and makes no memory access.
  - Valid load: go to LOAD.
  - SW: go to STORE.
  - SB/SH: go to RMW_RD.
- LOAD: mem_read=1. Capture mem_rdata, then select the byte or half using addr_q[1:0] and extend it into rdata. LB/LH sign-extend; LBU/LHU zero-extend. Next state is RESP.
- STORE: mem_write=1, mem_wdata=wdata_q. Next state is RESP.
- RMW_RD: mem_read=1. Capture the word into merge_q. Next state is RMW_WR.
- RMW_WR: mem_write=1. mem_wdata is merge_q with the byte or half at the addr_q offset replaced by wdata_q[7:0] or wdata_q[15:0]. Next state is RESP.
- RESP: done=1, with err as classified. Next state is IDLE.
- Memory strobes outside their states are 0. mem_addr is driven from addr_q in every state.
- A store never updates rdata. An error never updates rdata.

## Timing
- Reset values: state=IDLE, busy=0, done=0, err=0, rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Latency is counted from the req-accept edge (cycle 0) to the done cycle:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- req while busy=1, including the RESP cycle, is ignored. It is not queued. Back-to-back throughput is one request per 3 cycles for SW and loads.
- The write lands at the posedge that ends the STORE or RMW_WR cycle.
- mem_write is gated by !rst. Reset during any state returns to IDLE at the next edge, with no done pulse and no partial write.
- Inputs are sampled only at accept. Changes to inputs while busy have no effect.

## Structure
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum.
  - MEM_BYTES default.
- Sub-module lsu_align (combinational), with two functions:
  - load extract/extend: word, offset, funct3 → rdata.
  - store merge: old word, wdata, offset, funct3 → new word.
- Top level: FSM, input registers, merge_q, error classifier.

## Test plan
- Pre-load word 0x8 = 0x12F45678, then LB addr 0xA → done at cycle 2, rdata=0xFFFFFFF4, err=0. Then LBU at the same address → rdata=0x000000F4.
- SW 0xDEADBEEF to 0x10, then LH 0x12 → rdata=0xFFFFDEAD. Then LHU 0x10 → rdata=0x0000BEEF.
- Word 0x20 = 0x11223344. SB wdata=0xAA to addr 0x21 → mem_write exactly once at cycle 2. A following LW 0x20 returns 0x1122AA44.
- LW 0x6, SH 0x3, LB 0x100 (MEM_BYTES=256), load funct3=3 → each gives done at cycle 1 with err=1, mem_read=mem_write=0 throughout, rdata unchanged.
- Assert req every cycle during an SB → only the first request executes; busy is high for cycles 1–3; exactly one done pulse.
- Assert rst in the RMW_WR cycle → no memory write, no done; IDLE and all outputs are at reset values next cycle; the next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
`timescale 1ns/1ps
package lsu_pkg;

   // Default attached memory size in bytes (64 words).
   localparam int MEM_BYTES_DEF = 256;

   // RV32I funct3 width/sign codes for loads and stores.
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   // Controller states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STORE  = 3'd2,
      ST_RMW_RD = 3'd3,
      ST_RMW_WR = 3'd4,
      ST_RESP   = 3'd5
   } lsu_state_t;

   // True when funct3 is a legal code for the given direction.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      if (is_store)
         f3_legal = (f3 <= F3_W);
      else
         f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane handling: load extraction with extension and store merge.
`timescale 1ns/1ps
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_load_word,
   input  logic [31:0] i_old_word,
   input  logic [15:0] i_wdata,
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_word
);

   // Pick the addressed byte/half out of the word and sign/zero extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    load_extend = {{24{b[7]}}, b};
         F3_BU:   load_extend = {24'h0, b};
         F3_H:    load_extend = {{16{h[15]}}, h};
         F3_HU:   load_extend = {16'h0, h};
         default: load_extend = word;
      endcase
   endfunction

   // Replace the addressed byte/half of the old word with the new store data.
   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [15:0] wd,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [31:0] w;
      w = old;
      if (f3[1:0] == 2'b01) begin
         if (off[1]) w[31:16] = wd;
         else        w[15:0]  = wd;
      end else begin
         case (off)
            2'd0:    w[7:0]   = wd[7:0];
            2'd1:    w[15:8]  = wd[7:0];
            2'd2:    w[23:16] = wd[7:0];
            default: w[31:24] = wd[7:0];
         endcase
      end
      store_merge = w;
   endfunction

   // Both paths are purely combinational.
   always_comb begin
      o_load_data  = load_extend(i_load_word, i_offset, i_funct3);
      o_store_word = store_merge(i_old_word, i_wdata, i_offset, i_funct3);
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, alignment/range checks,
// sub-word loads with extension and sub-word stores via read-modify-write.
`timescale 1ns/1ps
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  r_state;
   lsu_state_t  w_state_next;

   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_merge;
   logic [31:0] r_rdata;
   logic        r_err;

   logic        w_f3_illegal;
   logic        w_misalign;
   logic        w_out_of_range;
   logic        w_req_err;
   logic        w_accept;
   logic [31:0] w_load_data;
   logic [31:0] w_store_word;

   assign w_accept = (r_state == ST_IDLE) && req;

   // Classify the incoming request from the live inputs at the accept edge.
   always_comb begin
      w_f3_illegal   = !f3_legal(we, funct3);
      w_misalign     = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      w_out_of_range = (addr >= 32'(MEM_BYTES));
      w_req_err      = w_f3_illegal || w_misalign || w_out_of_range;
   end

   lsu_align u_align (
      .i_load_word  (mem_rdata),
      .i_old_word   (r_merge),
      .i_wdata      (r_wdata[15:0]),
      .i_offset     (r_addr[1:0]),
      .i_funct3     (r_funct3),
      .o_load_data  (w_load_data),
      .o_store_word (w_store_word)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state decode and per-state memory strobes / handshake outputs.
   always_comb begin
      w_state_next = r_state;
      busy         = (r_state != ST_IDLE);
      done         = 1'b0;
      err          = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_wdata    = 32'h0;
      case (r_state)
         ST_IDLE: begin
            if (req) begin
               if (w_req_err)          w_state_next = ST_RESP;
               else if (!we)           w_state_next = ST_LOAD;
               else if (funct3 == F3_W) w_state_next = ST_STORE;
               else                    w_state_next = ST_RMW_RD;
            end
         end
         ST_LOAD: begin
            mem_read     = 1'b1;
            w_state_next = ST_RESP;
         end
         ST_STORE: begin
            mem_write    = r_we && !rst;
            mem_wdata    = r_wdata;
            w_state_next = ST_RESP;
         end
         ST_RMW_RD: begin
            mem_read     = 1'b1;
            w_state_next = ST_RMW_WR;
         end
         ST_RMW_WR: begin
            mem_write    = r_we && !rst;
            mem_wdata    = w_store_word;
            w_state_next = ST_RESP;
         end
         ST_RESP: begin
            done         = 1'b1;
            err          = r_err;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Request capture; everything downstream works from these copies only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= 32'h0;
         r_wdata  <= 32'h0;
         r_err    <= 1'b0;
      end else if (w_accept) begin
         r_we     <= we;
         r_funct3 <= funct3;
         r_addr   <= addr;
         r_wdata  <= wdata;
         r_err    <= w_req_err;
      end
   end

   // Old word for sub-word stores, captured during the read half of RMW.
   always_ff @(posedge clk) begin
      if (rst)                      r_merge <= 32'h0;
      else if (r_state == ST_RMW_RD) r_merge <= mem_rdata;
   end

   // Load result; only successful loads ever update it.
   always_ff @(posedge clk) begin
      if (rst)                    r_rdata <= 32'h0;
      else if (r_state == ST_LOAD) r_rdata <= w_load_data;
   end

   assign rdata    = r_rdata;
   assign mem_addr = {r_addr[31:2], 2'b00};

endmodule
